// File: rtl/video_timing_pkg.sv
// Shared timing defaults, controller state encoding and pixel helpers
// for the video output path.
package video_timing_pkg;

  localparam int DEF_H_DISP = 1280;
  localparam int DEF_H_FP   = 110;
  localparam int DEF_H_SYNC = 40;
  localparam int DEF_H_BP   = 220;
  localparam int DEF_V_DISP = 720;
  localparam int DEF_V_FP   = 5;
  localparam int DEF_V_SYNC = 5;
  localparam int DEF_V_BP   = 20;

  localparam int DEF_FIFO_DEPTH  = 2048;
  localparam int DEF_PRIME_LEVEL = 640;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Widen each channel by replicating its top bits so full scale maps to 8'hFF.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock pixel buffer with show-ahead read data, occupancy level
// and a synchronous flush that empties it in one cycle.
module sync_fifo #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 16
) (
  input  logic                     video_clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // A read in the same cycle frees the slot, so a write at full still lands.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge video_clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_wr) - LW'(do_rd);
    end
  end

endmodule

// File: rtl/video_timing_out.sv
// Buffers RGB565 pixels and, once primed, plays them out as RGB888 with
// DE/HS/VS raster timing; any buffer error drops back to WAIT at frame end.
module video_timing_out
  import video_timing_pkg::*;
#(
  parameter int          H_DISP      = DEF_H_DISP,
  parameter int          H_FP        = DEF_H_FP,
  parameter int          H_SYNC      = DEF_H_SYNC,
  parameter int          H_BP        = DEF_H_BP,
  parameter int          V_DISP      = DEF_V_DISP,
  parameter int          V_FP        = DEF_V_FP,
  parameter int          V_SYNC      = DEF_V_SYNC,
  parameter int          V_BP        = DEF_V_BP,
  parameter int          FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int          PRIME_LEVEL = DEF_PRIME_LEVEL,
  parameter logic [23:0] FILL        = 24'h000000
) (
  input  logic        video_clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_vs,
  input  logic        clr_status,
  output logic [23:0] out_rgb,
  output logic        out_de,
  output logic        out_hs,
  output logic        out_vs,
  output logic        locked,
  output logic        underflow,
  output logic        overflow
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  state_e        state;
  state_e        state_nxt;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          pending;
  logic [15:0]   rd_data;
  logic [LW-1:0] level;
  logic          empty;
  logic          full;
  logic          active;
  logic          hs_win;
  logic          vs_win;
  logic          frame_end;
  logic          to_wait;
  logic          rd_en;
  logic          wr_en;
  logic          uf_evt;
  logic          ov_evt;
  logic          flush;

  assign active    = (state == RUN) && (hcnt < HW'(H_DISP)) && (vcnt < VW'(V_DISP));
  assign hs_win    = (state == RUN) && (hcnt >= HW'(H_DISP + H_FP))
                     && (hcnt < HW'(H_DISP + H_FP + H_SYNC));
  assign vs_win    = (state == RUN) && (vcnt >= VW'(V_DISP + V_FP))
                     && (vcnt < VW'(V_DISP + V_FP + V_SYNC));
  assign frame_end = (hcnt == HW'(H_TOT - 1)) && (vcnt == VW'(V_TOT - 1));
  assign to_wait   = (state == RUN) && pending && frame_end;

  assign rd_en  = active && !empty;
  assign uf_evt = active && empty;
  assign wr_en  = in_valid && (state != WAIT);
  assign ov_evt = wr_en && full && !rd_en;
  // The buffer is held empty for the whole of WAIT, including the entry cycle.
  assign flush  = (state == WAIT) || to_wait;
  assign locked = (state == RUN);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .video_clk (video_clk),
    .rst       (rst),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_data   (in_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .level     (level),
    .empty     (empty),
    .full      (full)
  );

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      state <= WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT:    if (in_vs) state_nxt = PRIME;
      PRIME:   if (level >= LW'(PRIME_LEVEL)) state_nxt = RUN;
      RUN:     if (to_wait) state_nxt = WAIT;
      default: state_nxt = WAIT;
    endcase
  end

  // Counters sit at zero outside RUN so the first RUN cycle is always (0,0).
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (state != RUN) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == HW'(H_TOT - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VW'(V_TOT - 1)) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      out_rgb <= '0;
      out_de  <= 1'b0;
      out_hs  <= 1'b0;
      out_vs  <= 1'b0;
    end else begin
      out_de  <= active;
      out_hs  <= hs_win;
      out_vs  <= vs_win;
      out_rgb <= !active ? 24'h000000 : (empty ? FILL : rgb565_to_888(rd_data));
    end
  end

  // A new event in the same cycle as clr_status keeps its flag set.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
      pending   <= 1'b0;
    end else begin
      underflow <= (underflow && !clr_status) || uf_evt;
      overflow  <= (overflow && !clr_status) || ov_evt;
      pending   <= to_wait ? 1'b0 : (pending || uf_evt || ov_evt);
    end
  end

endmodule

// File: tb/tb_video_timing_out.sv
// Self-checking bench: a queue-based reference model runs beside a scaled-down
// raster; scenario tasks add targeted checks on top of the per-cycle comparison.
module tb_video_timing_out;

  localparam int HD = 16, HF = 3, HS = 4, HB = 5;
  localparam int VD = 6,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int DEPTH = 32;
  localparam int PRIME = 8;
  localparam logic [23:0] FILL = 24'h123456;

  logic        video_clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid, in_vs, clr_status;
  logic [23:0] out_rgb;
  logic        out_de, out_hs, out_vs, locked, underflow, overflow;

  logic [15:0] b_data;
  logic        b_valid, b_vs, b_clr;
  logic [23:0] o2_rgb;
  logic        o2_de, o2_hs, o2_vs, o2_locked, o2_underflow, o2_overflow;

  int checks = 0;
  int passed = 0;

  video_timing_out #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PRIME), .FILL(FILL)
  ) dut (
    .video_clk(video_clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_vs(in_vs), .clr_status(clr_status), .out_rgb(out_rgb), .out_de(out_de),
    .out_hs(out_hs), .out_vs(out_vs), .locked(locked), .underflow(underflow),
    .overflow(overflow)
  );

  // Second instance whose prime level can never be reached, for overflow checks.
  video_timing_out #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(63), .FILL(FILL)
  ) dut_ovf (
    .video_clk(video_clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
    .in_vs(b_vs), .clr_status(b_clr), .out_rgb(o2_rgb), .out_de(o2_de),
    .out_hs(o2_hs), .out_vs(o2_vs), .locked(o2_locked), .underflow(o2_underflow),
    .overflow(o2_overflow)
  );

  initial begin
    video_clk = 1'b0;
    forever #5 video_clk = ~video_clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [23:0] expand565(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
  endfunction

  // Reference model: mode 0 idle, 1 filling, 2 showing; the buffer is a plain queue.
  logic [15:0] mq[$];
  int          m_mode = 0, m_h = 0, m_v = 0, m_lvl;
  bit          m_pend = 0, m_act, m_uf, m_rd, m_wr, m_ov, m_fin;
  logic [23:0] e_rgb = '0;
  logic        e_de = 0, e_hs = 0, e_vs = 0, e_lock = 0, e_uf = 0, e_ov = 0;

  always @(posedge video_clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_mode = 0; m_h = 0; m_v = 0; m_pend = 0;
      e_rgb = '0; e_de = 0; e_hs = 0; e_vs = 0; e_lock = 0; e_uf = 0; e_ov = 0;
    end else begin
      m_lvl = mq.size();
      m_act = (m_mode == 2) && (m_h < HD) && (m_v < VD);
      m_uf  = m_act && (m_lvl == 0);
      m_rd  = m_act && (m_lvl > 0);
      m_wr  = in_valid && (m_mode != 0);
      m_ov  = m_wr && (m_lvl == DEPTH) && !m_rd;
      m_fin = (m_mode == 2) && m_pend && (m_h == HT - 1) && (m_v == VT - 1);
      e_de  = m_act;
      e_hs  = (m_mode == 2) && (m_h >= HD + HF) && (m_h < HD + HF + HS);
      e_vs  = (m_mode == 2) && (m_v >= VD + VF) && (m_v < VD + VF + VS);
      e_rgb = !m_act ? 24'h0 : (m_uf ? FILL : expand565(mq[0]));
      if (m_rd) void'(mq.pop_front());
      if (m_wr && !m_ov) mq.push_back(in_data);
      e_uf   = (e_uf && !clr_status) || m_uf;
      e_ov   = (e_ov && !clr_status) || m_ov;
      m_pend = m_pend || m_uf || m_ov;
      if (m_mode == 0) begin
        mq.delete();
        if (in_vs) m_mode = 1;
      end else if (m_mode == 1) begin
        if (m_lvl >= PRIME) begin m_mode = 2; m_h = 0; m_v = 0; end
      end else if (m_fin) begin
        m_mode = 0; mq.delete(); m_pend = 0; m_h = 0; m_v = 0;
      end else begin
        m_h++;
        if (m_h == HT) begin
          m_h = 0;
          m_v++;
          if (m_v == VT) m_v = 0;
        end
      end
      e_lock = (m_mode == 2);
    end
  end

  // Per-cycle comparison against the model; scenario tasks judge the tally.
  bit          cmp_en = 0;
  int          mm_cycles = 0;
  logic [29:0] mm_act, mm_exp;

  always @(negedge video_clk) begin
    if (cmp_en && ({out_rgb, out_de, out_hs, out_vs, locked, underflow, overflow} !==
                   {e_rgb, e_de, e_hs, e_vs, e_lock, e_uf, e_ov})) begin
      mm_cycles++;
      mm_act = {out_rgb, out_de, out_hs, out_vs, locked, underflow, overflow};
      mm_exp = {e_rgb, e_de, e_hs, e_vs, e_lock, e_uf, e_ov};
    end
  end

  task automatic drive_stream(input bit on);
    in_valid = on && (m_mode == 2) && (m_h < HD) && (m_v < VD);
    in_data  = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge video_clk);
    checks++;
    if ({out_rgb, out_de, out_hs, out_vs, locked, underflow, overflow} !== 30'd0)
      $display("[TB] FAIL reset_main: got %0h, want 0",
               {out_rgb, out_de, out_hs, out_vs, locked, underflow, overflow});
    else passed++;
    checks++;
    if ({o2_rgb, o2_de, o2_hs, o2_vs, o2_locked, o2_underflow, o2_overflow} !== 30'd0)
      $display("[TB] FAIL reset_ovf: got %0h, want 0",
               {o2_rgb, o2_de, o2_hs, o2_vs, o2_locked, o2_underflow, o2_overflow});
    else passed++;
    rst = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge video_clk);
    checks++;
    if ({out_de, locked} !== 2'b00)
      $display("[TB] FAIL reset_release: got de/locked %b, want 00", {out_de, locked});
    else passed++;
  endtask

  task automatic test_prime_lock();
    logic [15:0] pix [PRIME];
    logic [23:0] want [3];
    int start;
    start = mm_cycles;
    pix[0] = 16'hF800; pix[1] = 16'h07E0; pix[2] = 16'h001F;
    for (int i = 3; i < PRIME; i++) pix[i] = 16'($urandom);
    want[0] = 24'hFF0000; want[1] = 24'h00FF00; want[2] = 24'h0000FF;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom);
      @(negedge video_clk);
    end
    in_valid = 1'b0; in_vs = 1'b1;
    @(negedge video_clk);
    in_vs = 1'b0;
    for (int i = 0; i < PRIME; i++) begin
      in_valid = 1'b1; in_data = pix[i];
      @(negedge video_clk);
    end
    in_valid = 1'b0;
    checks++;
    if (locked !== 1'b0) $display("[TB] FAIL prime_not_yet: got locked %b, want 0", locked);
    else passed++;
    @(negedge video_clk);
    checks++;
    if (locked !== 1'b1) $display("[TB] FAIL prime_locked: got locked %b, want 1", locked);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      drive_stream(1);
      @(negedge video_clk);
      checks++;
      if ({out_de, out_rgb} !== {1'b1, want[k]})
        $display("[TB] FAIL first_pixel%0d: got de=%b rgb=%h, want de=1 rgb=%h",
                 k, out_de, out_rgb, want[k]);
      else passed++;
    end
    checks++;
    if (mm_cycles - start !== 0)
      $display("[TB] FAIL prime_model: got %0d bad cycles (last %h vs %h), want 0",
               mm_cycles - start, mm_act, mm_exp);
    else passed++;
  endtask

  task automatic test_steady_frame();
    int de_n = 0, hs_n = 0, vs_n = 0, gap = -1, last_de = -1, start;
    bit prev_vs = 1'b0;
    start = mm_cycles;
    for (int c = 0; c < 2 * FRAME; c++) begin
      drive_stream(1);
      @(negedge video_clk);
      if (c >= FRAME) begin
        de_n += int'(out_de); hs_n += int'(out_hs); vs_n += int'(out_vs);
      end
      if (out_de) last_de = c;
      if (out_vs && !prev_vs && gap < 0 && last_de >= 0) gap = c - last_de;
      prev_vs = out_vs;
    end
    in_valid = 1'b0;
    checks++;
    if (de_n !== HD * VD) $display("[TB] FAIL steady_de: got %0d, want %0d", de_n, HD * VD);
    else passed++;
    checks++;
    if (hs_n !== HS * VT) $display("[TB] FAIL steady_hs: got %0d, want %0d", hs_n, HS * VT);
    else passed++;
    checks++;
    if (vs_n !== VS * HT) $display("[TB] FAIL steady_vs: got %0d, want %0d", vs_n, VS * HT);
    else passed++;
    checks++;
    if (gap !== (VD + VF) * HT - ((VD - 1) * HT + HD - 1))
      $display("[TB] FAIL steady_vs_start: got gap %0d, want %0d", gap,
               (VD + VF) * HT - ((VD - 1) * HT + HD - 1));
    else passed++;
    checks++;
    if ({underflow, overflow, locked} !== 3'b001)
      $display("[TB] FAIL steady_flags: got uf/ov/lock %b, want 001", {underflow, overflow, locked});
    else passed++;
    checks++;
    if (mm_cycles - start !== 0)
      $display("[TB] FAIL steady_model: got %0d bad cycles (last %h vs %h), want 0",
               mm_cycles - start, mm_act, mm_exp);
    else passed++;
  endtask

  task automatic test_underflow();
    int fill_n = 0, relock = 0, start;
    bit timeout = 1'b1;
    start = mm_cycles;
    for (int c = 0; c < 2 * FRAME; c++) begin
      in_valid = 1'b0; in_data = 16'($urandom);
      @(negedge video_clk);
      if (out_de && out_rgb == FILL) fill_n++;
      if (!locked) begin timeout = 1'b0; break; end
    end
    checks++;
    if (timeout !== 1'b0) $display("[TB] FAIL uf_unlock: got still locked, want unlocked at frame end");
    else passed++;
    checks++;
    if (fill_n == 0) $display("[TB] FAIL uf_fill: got %0d fill pixels, want >0", fill_n);
    else passed++;
    checks++;
    if (underflow !== 1'b1) $display("[TB] FAIL uf_flag: got %b, want 1", underflow);
    else passed++;
    for (int c = 0; c < FRAME; c++) begin
      in_valid = 1'b1; in_data = 16'($urandom);
      @(negedge video_clk);
      relock += int'(locked);
    end
    in_valid = 1'b0;
    checks++;
    if (relock !== 0) $display("[TB] FAIL uf_no_relock: got %0d locked cycles, want 0", relock);
    else passed++;
    clr_status = 1'b1;
    @(negedge video_clk);
    clr_status = 1'b0;
    checks++;
    if (underflow !== 1'b0) $display("[TB] FAIL uf_clear: got %b, want 0", underflow);
    else passed++;
    checks++;
    if (mm_cycles - start !== 0)
      $display("[TB] FAIL uf_model: got %0d bad cycles (last %h vs %h), want 0",
               mm_cycles - start, mm_act, mm_exp);
    else passed++;
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    int relock = 0;
    in_vs = 1'b1;
    @(negedge video_clk);
    in_vs = 1'b0;
    for (int i = 0; i < PRIME; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom);
      @(negedge video_clk);
    end
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (m_mode == 2 && m_v == 1 && m_h == 6) begin found = 1'b1; break; end
      drive_stream(1);
      @(negedge video_clk);
    end
    in_valid = 1'b0;
    checks++;
    if (found !== 1'b1 || out_de !== 1'b1)
      $display("[TB] FAIL rst_mid_line_setup: got reached=%b de=%b, want 1 1", found, out_de);
    else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_rgb, out_de, out_hs, out_vs, locked, underflow, overflow} !== 30'd0)
      $display("[TB] FAIL rst_mid_line: got %0h, want 0",
               {out_rgb, out_de, out_hs, out_vs, locked, underflow, overflow});
    else passed++;
    #1 rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      in_valid = 1'b1; in_data = 16'($urandom);
      @(negedge video_clk);
      relock += int'(locked);
    end
    in_valid = 1'b0;
    checks++;
    if (relock !== 0) $display("[TB] FAIL rst_back_to_wait: got %0d locked cycles, want 0", relock);
    else passed++;
  endtask

  task automatic test_random(input int rate, input int ncyc, input string name);
    int start;
    start = mm_cycles;
    for (int c = 0; c < ncyc; c++) begin
      in_valid   = ($urandom_range(99) < rate);
      in_data    = 16'($urandom);
      in_vs      = ($urandom_range(99) < 3);
      clr_status = ($urandom_range(99) < 5);
      @(negedge video_clk);
    end
    in_valid = 1'b0; in_vs = 1'b0; clr_status = 1'b0;
    checks++;
    if (mm_cycles - start !== 0)
      $display("[TB] FAIL %s: got %0d bad cycles (last %h vs %h), want 0",
               name, mm_cycles - start, mm_act, mm_exp);
    else passed++;
  endtask

  task automatic test_overflow();
    b_vs = 1'b1;
    @(negedge video_clk);
    b_vs = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      b_valid = 1'b1; b_data = 16'($urandom);
      @(negedge video_clk);
    end
    b_valid = 1'b0;
    checks++;
    if (o2_overflow !== 1'b0) $display("[TB] FAIL ovf_at_full: got %b, want 0", o2_overflow);
    else passed++;
    b_valid = 1'b1; b_clr = 1'b1;
    @(negedge video_clk);
    b_valid = 1'b0; b_clr = 1'b0;
    checks++;
    if (o2_overflow !== 1'b1) $display("[TB] FAIL ovf_clr_same_cycle: got %b, want 1", o2_overflow);
    else passed++;
    b_clr = 1'b1;
    @(negedge video_clk);
    b_clr = 1'b0;
    checks++;
    if (o2_overflow !== 1'b0) $display("[TB] FAIL ovf_clear: got %b, want 0", o2_overflow);
    else passed++;
    b_valid = 1'b1;
    @(negedge video_clk);
    b_valid = 1'b0;
    checks++;
    if ({o2_overflow, o2_locked} !== 2'b10)
      $display("[TB] FAIL ovf_again: got ov/lock %b, want 10", {o2_overflow, o2_locked});
    else passed++;
  endtask

  initial begin
    in_data = '0; in_valid = 1'b0; in_vs = 1'b0; clr_status = 1'b0;
    b_data = '0; b_valid = 1'b0; b_vs = 1'b0; b_clr = 1'b0;
    rst = 1'b0;
    test_reset();
    test_prime_lock();
    test_steady_frame();
    test_underflow();
    test_async_reset();
    test_random(70, 1200, "random_heavy");
    test_random(25, 1200, "random_light");
    test_overflow();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_out.md
VIDEO_TIMING_OUT -- requirements
Module: video_timing_out

Interface
REQ-001 SHALL have parameter H_DISP, default 1280, meaning active pixels per line.
REQ-002 SHALL have parameters H_FP=110, H_SYNC=40, H_BP=220, V_DISP=720, V_FP=5, V_SYNC=5, V_BP=20, meaning 720p60 blanking in pixels/lines.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2048, meaning pixel buffer entries (power of two).
REQ-004 SHALL have parameter PRIME_LEVEL, default 640, meaning buffer fill required before timing starts.
REQ-005 SHALL have parameter FILL, default 24'h000000, meaning colour driven on underflow.
REQ-006 SHALL have ports: video_clk in 1 pixel clock; rst in 1 asynchronous active-high reset.
REQ-007 SHALL have ports: in_data in 16 RGB565 pixel; in_valid in 1 pixel strobe; in_vs in 1 one-cycle end-of-frame pulse; clr_status in 1 clears sticky flags.
REQ-008 SHALL have ports: out_rgb out 24 RGB888; out_de out 1; out_hs out 1; out_vs out 1 (both syncs active-high).
REQ-009 SHALL have ports: locked out 1 timing running; underflow out 1 sticky; overflow out 1 sticky.

Function
REQ-010 SHALL use states WAIT, PRIME, RUN.
REQ-011 WAIT: buffer held empty, in_valid data discarded; in_vs -> PRIME.
REQ-012 PRIME: in_valid pixels written; level >= PRIME_LEVEL -> RUN with hcnt=0, vcnt=0 on the next cycle.
REQ-013 RUN: hcnt counts 0..H_DISP+H_FP+H_SYNC+H_BP-1 (1649) and wraps; vcnt increments on hcnt wrap, range 0..749, wraps to 0.
REQ-014 Active region: hcnt<H_DISP and vcnt<V_DISP; hs for hcnt in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC); vs for vcnt in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC).
REQ-015 All video outputs SHALL be registered, appearing 1 cycle after the counter value that produced them; out_rgb = 0 when out_de=0.
REQ-016 Buffer SHALL be read once per active cycle; out_rgb = {R5,R5[4:2], G6,G6[5:4], B5,B5[4:2]}.
REQ-017 Underflow (active cycle, buffer empty): out_rgb=FILL, out_de still 1, underflow set, error pending flag set.
REQ-018 Overflow (in_valid, buffer full): pixel dropped, overflow set, error pending flag set.
REQ-019 In RUN, error pending at final cycle of frame (hcnt=1649, vcnt=749) -> WAIT, buffer flushed, pending cleared, locked=0.
REQ-020 Simultaneous write and read SHALL both occur; level unchanged; write at full with simultaneous read is not overflow.
REQ-021 in_vs in PRIME or RUN SHALL be ignored.
REQ-022 clr_status clears underflow/overflow; a same-cycle new event wins (flag stays 1).
REQ-023 locked = 1 exactly while in RUN.

Reset
REQ-024 Asynchronous rst SHALL force WAIT, counters 0, buffer empty, all outputs 0, flags 0, pending 0, effective mid-frame.

Structure
REQ-025 Timing constants and state encoding SHALL live in shared package video_timing_pkg.
REQ-026 Buffer SHALL be sub-module sync_fifo (single clock, level output, flush input, registered-free read data).

Verification
REQ-027 Reset, in_vs, then 640 pixels -> locked=1 next cycle; first out_de 1 cycle later with pixel 0.
REQ-028 Pixel 16'hF800 -> out_rgb 24'hFF0000; 16'h07E0 -> 24'h00FF00; 16'h001F -> 24'h0000FF.
REQ-029 Steady stream, 1280 pixels per line -> out_de high 1280 cycles per 1650; hs 40 cycles; vs 5 lines starting vcnt 725; no flags.
REQ-030 Stop input mid-frame -> FILL on empty active cycles, underflow=1, locked=0 after cycle (1649,749), restart needs in_vs.
REQ-031 2049 writes without reads during PRIME (PRIME_LEVEL=4095 override) -> overflow=1; clr_status same cycle as overflow -> overflow remains 1.
REQ-032 rst asserted mid-line in RUN -> all outputs 0 immediately, state WAIT.
